// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one byte/half/word data memory between the CPU MEM stage
// (port 0) and a DMA/debug loader (port 1). A combinational grant picks the
// winner, its attributes are registered into a one-cycle DM access stage, and
// a registered response is returned to the winning port two cycles after grant.
module dm_arbiter #(
  parameter int RR_MODE  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  wbh0,
  input  logic [1:0]  wbh1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        rerr0,
  output logic        rerr1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [1:0]  dm_wbh,
  output logic        dm_we,
  input  logic [31:0] dm_rd
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  // Size/alignment legality: 00 word, 01 byte, 10 half, 11 illegal.
  function automatic logic misaligned(input logic [1:0] wbh, input logic [1:0] lsb);
    logic err;
    case (wbh)
      2'b00:   err = (lsb != 2'b00);
      2'b01:   err = 1'b0;
      2'b10:   err = lsb[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  logic           last_r;       // 1 = port 1 was granted most recently
  logic [WCW-1:0] wait_cnt_r;   // consecutive losing cycles of port 1
  logic           acc_valid_r;
  logic           acc_port_r;
  logic           acc_we_r;
  logic           acc_err_r;

  logic           pick1_s;
  logic           sel_we_s;
  logic [1:0]     sel_wbh_s;
  logic [31:0]    sel_addr_s;
  logic [31:0]    sel_wd_s;
  logic           sel_err_s;
  logic           any_gnt_s;
  logic [31:0]    resp_data_s;

  // Arbitration: choose the winning port and raise at most one grant.
  always_comb begin
    pick1_s = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (req0 && req1) begin
      if (RR_MODE != 0) begin
        pick1_s = ~last_r;
      end else begin
        pick1_s = (wait_cnt_r == WAIT_LIMIT);
      end
    end else begin
      pick1_s = req1;
    end
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else begin
      gnt0 = (req0 | req1) & ~pick1_s;
      gnt1 = (req0 | req1) & pick1_s;
    end
  end

  // Winner attribute mux and alignment check feeding the access stage.
  always_comb begin
    sel_we_s   = 1'b0;
    sel_wbh_s  = 2'b00;
    sel_addr_s = 32'h0000_0000;
    sel_wd_s   = 32'h0000_0000;
    if (pick1_s) begin
      sel_we_s   = we1;
      sel_wbh_s  = wbh1;
      sel_addr_s = addr1;
      sel_wd_s   = wd1;
    end else begin
      sel_we_s   = we0;
      sel_wbh_s  = wbh0;
      sel_addr_s = addr0;
      sel_wd_s   = wd0;
    end
    sel_err_s = misaligned(sel_wbh_s, sel_addr_s[1:0]);
    any_gnt_s = gnt0 | gnt1;
  end

  // Round-robin pointer: remembers which port won the latest grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r <= 1'b1;
    end else if (any_gnt_s) begin
      last_r <= gnt1;
    end else begin
      last_r <= last_r;
    end
  end

  // Starvation counter for port 1 in fixed-priority mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (gnt1 || !req1) begin
      wait_cnt_r <= '0;
    end else if (wait_cnt_r != WAIT_LIMIT) begin
      wait_cnt_r <= wait_cnt_r + WCW'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Access stage: capture the granted request so it drives the DM next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_valid_r <= 1'b0;
      acc_port_r  <= 1'b0;
      acc_we_r    <= 1'b0;
      acc_err_r   <= 1'b0;
      dm_addr     <= 32'h0000_0000;
      dm_wd       <= 32'h0000_0000;
      dm_wbh      <= 2'b00;
    end else begin
      acc_valid_r <= any_gnt_s;
      if (any_gnt_s) begin
        acc_port_r <= gnt1;
        acc_we_r   <= sel_we_s;
        acc_err_r  <= sel_err_s;
        dm_addr    <= sel_addr_s;
        dm_wd      <= sel_wd_s;
        dm_wbh     <= sel_wbh_s;
      end else begin
        acc_port_r <= acc_port_r;
        acc_we_r   <= acc_we_r;
        acc_err_r  <= acc_err_r;
        dm_addr    <= dm_addr;
        dm_wd      <= dm_wd;
        dm_wbh     <= dm_wbh;
      end
    end
  end

  // Erroring accesses never write; reset kills a write already in the access stage.
  assign dm_we = acc_valid_r & acc_we_r & ~acc_err_r & ~reset;

  // Response payload: load data only for clean loads, zero otherwise.
  always_comb begin
    resp_data_s = 32'h0000_0000;
    if (acc_we_r || acc_err_r) begin
      resp_data_s = 32'h0000_0000;
    end else begin
      resp_data_s = dm_rd;
    end
  end

  // Response registers: one-cycle pulse to the port that owned the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rerr0   <= 1'b0;
      rerr1   <= 1'b0;
      rdata0  <= 32'h0000_0000;
      rdata1  <= 32'h0000_0000;
    end else begin
      rvalid0 <= acc_valid_r & ~acc_port_r;
      rvalid1 <= acc_valid_r & acc_port_r;
      rerr0   <= acc_valid_r & ~acc_port_r & acc_err_r;
      rerr1   <= acc_valid_r & acc_port_r & acc_err_r;
      rdata0  <= (acc_valid_r & ~acc_port_r) ? resp_data_s : 32'h0000_0000;
      rdata1  <= (acc_valid_r & acc_port_r) ? resp_data_s : 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a round-robin instance backed by a byte-wide
// DM model, and a fixed-priority instance (MAX_WAIT=3) sharing its inputs.
module tb_dm_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [1:0]  wbh0, wbh1;
  logic [31:0] addr0, addr1, wd0, wd1;

  logic        gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, dm_we;
  logic [31:0] rdata0, rdata1, dm_addr, dm_wd, dm_rd;
  logic [1:0]  dm_wbh;

  logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_rerr0, fp_rerr1, fp_dm_we;
  logic [31:0] fp_rdata0, fp_rdata1, fp_dm_addr, fp_dm_wd, fp_dm_rd;
  logic [1:0]  fp_dm_wbh;

  int n_vec;
  int n_miss;

  logic [7:0] mem [0:255];
  logic [7:0] ma;

  dm_arbiter #(.RR_MODE(1), .MAX_WAIT(4)) u_rr (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wbh0(wbh0), .wbh1(wbh1), .addr0(addr0), .addr1(addr1),
    .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rerr0(rerr0), .rerr1(rerr1), .rdata0(rdata0), .rdata1(rdata1),
    .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_wbh(dm_wbh), .dm_we(dm_we),
    .dm_rd(dm_rd)
  );

  dm_arbiter #(.RR_MODE(0), .MAX_WAIT(3)) u_fp (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wbh0(wbh0), .wbh1(wbh1), .addr0(addr0), .addr1(addr1),
    .wd0(wd0), .wd1(wd1),
    .gnt0(fp_gnt0), .gnt1(fp_gnt1), .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1),
    .rerr0(fp_rerr0), .rerr1(fp_rerr1), .rdata0(fp_rdata0), .rdata1(fp_rdata1),
    .dm_addr(fp_dm_addr), .dm_wd(fp_dm_wd), .dm_wbh(fp_dm_wbh), .dm_we(fp_dm_we),
    .dm_rd(fp_dm_rd)
  );

  assign fp_dm_rd = 32'h0000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DM model: combinational sign-extending read.
  always_comb begin
    ma    = dm_addr[7:0];
    dm_rd = 32'h0000_0000;
    case (dm_wbh)
      2'b00:   dm_rd = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
      2'b01:   dm_rd = {{24{mem[ma][7]}}, mem[ma]};
      2'b10:   dm_rd = {{16{mem[ma + 8'd1][7]}}, mem[ma + 8'd1], mem[ma]};
      default: dm_rd = 32'h0000_0000;
    endcase
  end

  // DM model: clocked write of the right-aligned store data.
  always @(posedge clk) begin
    if (dm_we) begin
      mem[ma] <= dm_wd[7:0];
      if (dm_wbh != 2'b01) mem[ma + 8'd1] <= dm_wd[15:8];
      if (dm_wbh == 2'b00) begin
        mem[ma + 8'd2] <= dm_wd[23:16];
        mem[ma + 8'd3] <= dm_wd[31:24];
      end
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic r, input logic w, input logic [1:0] b,
                        input logic [31:0] a, input logic [31:0] d);
    req0 = r; we0 = w; wbh0 = b; addr0 = a; wd0 = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [1:0] b,
                        input logic [31:0] a, input logic [31:0] d);
    req1 = r; we1 = w; wbh1 = b; addr1 = a; wd1 = d;
  endtask

  logic [7:0] rr_pat;
  logic [7:0] fp_pat;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    rr_pat = 8'b1010_1010;
    fp_pat = 8'b1000_1000;

    // Reset state, with a request present to show grants are blocked.
    next_cycle();
    drive0(1'b1, 1'b1, 2'b00, 32'h10, 32'hFFFF_FFFF);
    @(negedge clk);
    check_vec("rst_gnt0", {31'd0, gnt0}, 32'd0);
    check_vec("rst_gnt1", {31'd0, gnt1}, 32'd0);
    check_vec("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    check_vec("rst_rdata0", rdata0, 32'd0);
    check_vec("rst_dm_we", {31'd0, dm_we}, 32'd0);
    check_vec("rst_dm_addr", dm_addr, 32'd0);
    next_cycle();
    reset = 1'b0;
    drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    check_vec("post_rst_dm_we", {31'd0, dm_we}, 32'd0);

    // Port 0 word store then back-to-back load from the same address.
    next_cycle();
    drive0(1'b1, 1'b1, 2'b00, 32'h10, 32'h1234_5678);
    @(negedge clk);
    check_vec("st_gnt0", {31'd0, gnt0}, 32'd1);
    check_vec("st_gnt1", {31'd0, gnt1}, 32'd0);
    next_cycle();
    drive0(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    @(negedge clk);
    check_vec("st_dm_we", {31'd0, dm_we}, 32'd1);
    check_vec("st_dm_addr", dm_addr, 32'h10);
    check_vec("st_dm_wd", dm_wd, 32'h1234_5678);
    check_vec("ld_gnt0", {31'd0, gnt0}, 32'd1);
    next_cycle();
    drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    check_vec("st_rvalid0", {31'd0, rvalid0}, 32'd1);
    check_vec("st_rdata0", rdata0, 32'd0);
    check_vec("ld_dm_we", {31'd0, dm_we}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_vec("ld_rvalid0", {31'd0, rvalid0}, 32'd1);
    check_vec("ld_rdata0", rdata0, 32'h1234_5678);
    check_vec("ld_rerr0", {31'd0, rerr0}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_vec("ld_rvalid0_clr", {31'd0, rvalid0}, 32'd0);

    // Port 1 misaligned word store, then word load showing memory intact.
    next_cycle();
    drive1(1'b1, 1'b1, 2'b00, 32'h13, 32'hDEAD_BEEF);
    @(negedge clk);
    check_vec("mis_gnt1", {31'd0, gnt1}, 32'd1);
    next_cycle();
    drive1(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    @(negedge clk);
    check_vec("mis_dm_we", {31'd0, dm_we}, 32'd0);
    next_cycle();
    drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    check_vec("mis_rvalid1", {31'd0, rvalid1}, 32'd1);
    check_vec("mis_rerr1", {31'd0, rerr1}, 32'd1);
    check_vec("mis_rdata1", rdata1, 32'd0);
    check_vec("mis_rvalid0", {31'd0, rvalid0}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_vec("mis_ld_rdata1", rdata1, 32'h1234_5678);
    check_vec("mis_ld_rerr1", {31'd0, rerr1}, 32'd0);

    // Byte store 0xAB to 0x21, byte load back, word load of 0x20.
    next_cycle();
    drive0(1'b1, 1'b1, 2'b01, 32'h21, 32'h0000_00AB);
    next_cycle();
    drive0(1'b1, 1'b0, 2'b01, 32'h21, 32'h0);
    next_cycle();
    drive0(1'b1, 1'b0, 2'b00, 32'h20, 32'h0);
    @(negedge clk);
    check_vec("sb_rvalid0", {31'd0, rvalid0}, 32'd1);
    check_vec("sb_rdata0", rdata0, 32'd0);
    next_cycle();
    drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    check_vec("lb_rdata0", rdata0, 32'hFFFF_FFAB);
    next_cycle();
    @(negedge clk);
    check_vec("lw20_rdata0", rdata0, 32'h0000_AB00);

    // Illegal size, then misaligned half load.
    next_cycle();
    drive0(1'b1, 1'b0, 2'b11, 32'h20, 32'h0);
    next_cycle();
    drive0(1'b1, 1'b0, 2'b10, 32'h21, 32'h0);
    next_cycle();
    drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    check_vec("ill_rerr0", {31'd0, rerr0}, 32'd1);
    check_vec("ill_rdata0", rdata0, 32'd0);
    next_cycle();
    @(negedge clk);
    check_vec("half_mis_rerr0", {31'd0, rerr0}, 32'd1);

    // Reset asserted while a store sits in the access stage.
    next_cycle();
    drive0(1'b1, 1'b1, 2'b00, 32'h10, 32'h55AA_55AA);
    next_cycle();
    drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check_vec("rma_dm_we", {31'd0, dm_we}, 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_vec("rma_rvalid0", {31'd0, rvalid0}, 32'd0);
    check_vec("rma_dm_addr", dm_addr, 32'd0);
    check_vec("rma_dm_wd", dm_wd, 32'd0);
    check_vec("rma_dm_wbh", {30'd0, dm_wbh}, 32'd0);
    check_vec("rma_dm_we2", {31'd0, dm_we}, 32'd0);

    // Contention straight after reset: RR alternates, fixed priority guards port 1.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (i < 8) begin
        drive0(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
        drive1(1'b1, 1'b0, 2'b00, 32'h20, 32'h0);
      end else begin
        drive0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      end
      @(negedge clk);
      if (i < 8) begin
        check_vec($sformatf("rr_gnt1_c%0d", i), {31'd0, gnt1}, {31'd0, rr_pat[i]});
        check_vec($sformatf("rr_gnt0_c%0d", i), {31'd0, gnt0}, {31'd0, ~rr_pat[i]});
        check_vec($sformatf("fp_gnt1_c%0d", i), {31'd0, fp_gnt1}, {31'd0, fp_pat[i]});
        check_vec($sformatf("fp_gnt0_c%0d", i), {31'd0, fp_gnt0}, {31'd0, ~fp_pat[i]});
      end
      if (i >= 2) begin
        check_vec($sformatf("rr_rvalid1_c%0d", i), {31'd0, rvalid1}, {31'd0, rr_pat[i-2]});
        check_vec($sformatf("rr_rvalid0_c%0d", i), {31'd0, rvalid0}, {31'd0, ~rr_pat[i-2]});
        if (rr_pat[i-2]) begin
          check_vec($sformatf("rr_rdata1_c%0d", i), rdata1, 32'h0000_AB00);
        end else begin
          check_vec($sformatf("rr_rdata0_c%0d", i), rdata0, 32'h1234_5678);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester access controller that shares the single data memory (byte/half/word DM with combinational read and clocked write) between port 0 (CPU MEM stage) and port 1 (DMA/debug loader). It arbitrates, registers the winning request into a one-cycle DM access stage, checks alignment, and returns a registered response. Throughput is one access per cycle. It sits between the requesters and the DM's addr/wd/we/wbh/RD pins.

## Interface
- `RR_MODE`, default 1: 1 selects round-robin; 0 selects fixed priority to port 0 with a starvation guard.
- `MAX_WAIT`, default 4: in fixed-priority mode, the number of consecutive losing cycles for port 1 after which port 1 wins the next contention. Must be ≥ 1.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `req0` / `req1` input, 1 bit: access request. Request attributes must be held stable until `gnt` is seen.
- `we0` / `we1` input, 1 bit: 1 = store, 0 = load.
- `wbh0` / `wbh1` input, 2 bits: access size; 00 = word, 01 = byte, 10 = half, 11 = illegal.
- `addr0` / `addr1` input, 32 bits: byte address.
- `wd0` / `wd1` input, 32 bits: store data, right-aligned.
- `gnt0` / `gnt1` output, 1 bit: combinational; the request is accepted at the coming edge.
- `rvalid0` / `rvalid1` output, 1 bit: registered one-cycle response pulse.
- `rerr0` / `rerr1` output, 1 bit: registered; qualified by `rvalid`; marks a misaligned or illegal access.
- `rdata0` / `rdata1` output, 32 bits: registered load data as returned by the DM (extended); 0 for stores and errors.
- `dm_addr` output, 32 bits: registered address to the DM.
- `dm_wd` output, 32 bits: registered write data to the DM.
- `dm_wbh` output, 2 bits: registered size to the DM.
- `dm_we` output, 1 bit: DM write enable; equals `acc_valid & acc_we & ~acc_err & ~reset`.
- `dm_rd` input, 32 bits: combinational DM read data for the current `dm_addr`/`dm_wbh`.

## Operation

**Pipeline**
- Stage A (arbitrate): combinational `gnt` selection; the winner's attributes are captured at the edge.
- Stage B (access): the registered attributes drive the DM.
  - `acc_valid`, `acc_port`, `acc_we`, `acc_err` are internal registers.
  - At the edge ending stage B, the DM writes (if `dm_we`), and the response registers load.
  - For a load: `rdata = dm_rd`, `rerr = 0`.
  - For a store: `rdata = 0`.
  - For an error: `rdata = 0`, `rerr = 1`.
  - Only `rvalid` of `acc_port` is set; `rvalid` clears the following cycle unless a new response arrives.

**Alignment check (stage A, latched into `acc_err`)**
- Error if `wbh` = 11.
- Error if word with `addr[1:0]` ≠ 0.
- Error if half with `addr[0]` = 1.
- An erroring request is still granted and produces a response, but never writes the DM.

**Arbitration (both `gnt` forced 0 while `reset`)**
- Single requester: that port is granted.
- `RR_MODE` = 1, contention: grant the port not granted last. The `last` pointer updates on every grant and resets to 1, so port 0 wins the first contention.
- `RR_MODE` = 0, contention: grant port 0 unless `wait_cnt` = `MAX_WAIT`, in which case port 1 is granted.
  - `wait_cnt` width is clog2(`MAX_WAIT`+1).
  - Increments when `req1 & ~gnt1`, saturating at `MAX_WAIT`.
  - Clears on `gnt1`, on `~req1`, or on reset.
- At most one `gnt` per cycle.

**Reset values**
- All of the following are 0: `gnt*`, `rvalid*`, `rerr*`, `rdata*`, `dm_addr`, `dm_wd`, `dm_wbh`, `dm_we`, `acc_valid`, `wait_cnt`.
- `last` = 1.

## Timing
- Cycle N: `req` high and `gnt` high.
- Cycle N+1: DM driven; a store is committed at the end of N+1.
- Cycle N+2: `rvalid`, `rerr`, `rdata` valid for exactly one cycle.
- Load-after-store to the same address granted back-to-back: the load sees the new data, because the store commits before the load's access cycle.
- A requester may drop or change its request in cycle N+1. Holding `req` issues a new access each cycle it is granted.
- Reset asserted while an access is in stage B:
  - `dm_we` is 0 that cycle.
  - No `rvalid` appears in the following cycle.
  - All in-flight requests are discarded.
- `req` with `gnt` low: the requester must stall. The arbiter holds no state for it other than `wait_cnt`.

## Test plan
- **Port 0 word round-trip.** Port 0 stores 0x12345678 to 0x10, then loads from 0x10.
  - Store: `dm_we` high 1 cycle after `gnt0`.
  - Load: `rvalid0` 2 cycles after `gnt0`, with `rdata0` = 0x12345678 and `rerr0` = 0.
- **Round-robin contention.** `RR_MODE`=1; `req0` and `req1` held high 4 cycles after reset.
  - `gnt` sequence is 0,1,0,1.
  - `rvalid` pulses follow the same order 2 cycles later.
- **Fixed priority with starvation guard.** `RR_MODE`=0, `MAX_WAIT`=3; both requests held high.
  - `gnt0` for 3 cycles, `gnt1` on the 4th, then `gnt0` resumes.
  - `wait_cnt` returns to 0 after `gnt1`.
- **Misaligned store.** Port 1 stores a word to 0x13 with data 0xDEADBEEF.
  - `gnt1` high, `dm_we` stays 0.
  - `rvalid1` = 1, `rerr1` = 1, `rdata1` = 0.
  - A subsequent word load from 0x10 is unchanged.
- **Byte store/load.** Port 0 stores byte 0xAB to 0x21, then loads a byte from 0x21.
  - `rdata0` = 0xFFFFFFAB.
  - A word load from 0x20 shows 0x0000AB00 when the word was previously 0.
- **Reset mid-access.** A store is granted in cycle N and reset is asserted in cycle N+1.
  - `dm_we` = 0 in N+1 and the memory word is unchanged.
  - No `rvalid` in N+2.
  - All outputs are at their reset values in N+2.
